// File: rtl/traffic_phase_ctrl.sv
// Two-axis intersection phase scheduler: EW/NS green, yellow and all-red sequencing
// with demand-driven green, emergency all-red and an internal 1 s timebase.
module traffic_phase_ctrl #(
  parameter int unsigned TIME_1S  = 50000000,
  parameter int unsigned T_ALLRED = 1,
  parameter int unsigned G_MIN    = 3,
  parameter int unsigned G_MAX    = 6,
  parameter int unsigned T_YEL    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_ew,
  input  logic       req_ns,
  input  logic       emg,
  output logic [2:0] led_east,
  output logic [2:0] led_south,
  output logic [2:0] led_west,
  output logic [2:0] led_north,
  output logic [2:0] phase,
  output logic [3:0] sec_left,
  output logic       tick
);

  localparam logic [2:0]  PH_AR_A   = 3'd0;
  localparam logic [2:0]  PH_EW_G   = 3'd1;
  localparam logic [2:0]  PH_EW_Y   = 3'd2;
  localparam logic [2:0]  PH_AR_B   = 3'd3;
  localparam logic [2:0]  PH_NS_G   = 3'd4;
  localparam logic [2:0]  PH_NS_Y   = 3'd5;
  localparam logic [2:0]  LAMP_RED  = 3'b110;
  localparam logic [2:0]  LAMP_GRN  = 3'b101;
  localparam logic [2:0]  LAMP_YEL  = 3'b011;
  localparam logic [25:0] TICK_LAST = 26'(TIME_1S - 1);
  localparam logic [3:0]  ALLRED_S  = 4'(T_ALLRED);
  localparam logic [3:0]  GMIN_S    = 4'(G_MIN);
  localparam logic [3:0]  YEL_S     = 4'(T_YEL);
  localparam logic [4:0]  GMIN_W    = 5'(G_MIN);
  localparam logic [4:0]  GMAX_W    = 5'(G_MAX);

  logic [2:0]  phase_r, phase_nxt_s;
  logic [3:0]  sec_r, sec_nxt_s;
  logic [25:0] presc_r, presc_nxt_s;
  logic [3:0]  gcnt_r, gcnt_nxt_s;
  logic [4:0]  gsum_s;
  logic        tick_r, tick_s;
  logic        pend_ew_r, pend_ew_nxt_s;
  logic        pend_ns_r, pend_ns_nxt_s;
  logic        other_pend_s;
  logic [2:0]  led_ew_r, led_ew_nxt_s;
  logic [2:0]  led_ns_r, led_ns_nxt_s;

  // State register: phase, timers, pending requests and registered lamps
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_r   <= PH_AR_A;
      sec_r     <= ALLRED_S;
      presc_r   <= 26'd0;
      tick_r    <= 1'b0;
      gcnt_r    <= 4'd0;
      pend_ew_r <= 1'b0;
      pend_ns_r <= 1'b0;
      led_ew_r  <= LAMP_RED;
      led_ns_r  <= LAMP_RED;
    end else begin
      phase_r   <= phase_nxt_s;
      sec_r     <= sec_nxt_s;
      presc_r   <= presc_nxt_s;
      tick_r    <= (presc_nxt_s == TICK_LAST);
      gcnt_r    <= gcnt_nxt_s;
      pend_ew_r <= pend_ew_nxt_s;
      pend_ns_r <= pend_ns_nxt_s;
      led_ew_r  <= led_ew_nxt_s;
      led_ns_r  <= led_ns_nxt_s;
    end
  end

  // Next-state logic: phase sequencing, timers and request latching
  always_comb begin
    tick_s       = (presc_r == TICK_LAST);
    gsum_s       = {1'b0, gcnt_r} + 5'd1;
    other_pend_s = (phase_r == PH_EW_G) ? pend_ns_r : pend_ew_r;
    phase_nxt_s  = phase_r;
    sec_nxt_s    = sec_r;
    gcnt_nxt_s   = gcnt_r;
    presc_nxt_s  = tick_s ? 26'd0 : presc_r + 26'd1;
    case (phase_r)
      PH_AR_A, PH_AR_B: begin
        // Emergency parks the clearance phase with its full duration still ahead
        if (emg) begin
          presc_nxt_s = 26'd0;
          sec_nxt_s   = ALLRED_S;
        end else if (tick_s) begin
          if (sec_r <= 4'd1) begin
            phase_nxt_s = (phase_r == PH_AR_A) ? PH_EW_G : PH_NS_G;
            sec_nxt_s   = GMIN_S;
            gcnt_nxt_s  = 4'd0;
          end else begin
            sec_nxt_s = sec_r - 4'd1;
          end
        end else begin
          sec_nxt_s = sec_r;
        end
      end
      PH_EW_G, PH_NS_G: begin
        if (emg) begin
          phase_nxt_s = (phase_r == PH_EW_G) ? PH_EW_Y : PH_NS_Y;
          sec_nxt_s   = YEL_S;
          presc_nxt_s = 26'd0;
        end else if (tick_s) begin
          gcnt_nxt_s = gsum_s[3:0];
          if (gsum_s >= GMIN_W) begin
            if (other_pend_s || (gsum_s >= GMAX_W)) begin
              phase_nxt_s = (phase_r == PH_EW_G) ? PH_EW_Y : PH_NS_Y;
              sec_nxt_s   = YEL_S;
            end else begin
              sec_nxt_s = 4'd1;
            end
          end else begin
            sec_nxt_s = sec_r - 4'd1;
          end
        end else begin
          sec_nxt_s = sec_r;
        end
      end
      PH_EW_Y, PH_NS_Y: begin
        if (tick_s) begin
          if (sec_r <= 4'd1) begin
            phase_nxt_s = (phase_r == PH_EW_Y) ? PH_AR_B : PH_AR_A;
            sec_nxt_s   = ALLRED_S;
          end else begin
            sec_nxt_s = sec_r - 4'd1;
          end
        end else begin
          sec_nxt_s = sec_r;
        end
      end
      default: begin
        phase_nxt_s = PH_AR_A;
        sec_nxt_s   = ALLRED_S;
        presc_nxt_s = 26'd0;
        gcnt_nxt_s  = 4'd0;
      end
    endcase

    // Entry into a green wins over a same-cycle request for that green
    if ((phase_r != PH_EW_G) && (phase_nxt_s == PH_EW_G)) begin
      pend_ew_nxt_s = 1'b0;
    end else if (req_ew && (phase_r != PH_EW_G)) begin
      pend_ew_nxt_s = 1'b1;
    end else begin
      pend_ew_nxt_s = pend_ew_r;
    end
    if ((phase_r != PH_NS_G) && (phase_nxt_s == PH_NS_G)) begin
      pend_ns_nxt_s = 1'b0;
    end else if (req_ns && (phase_r != PH_NS_G)) begin
      pend_ns_nxt_s = 1'b1;
    end else begin
      pend_ns_nxt_s = pend_ns_r;
    end
  end

  // Output decode: lamp patterns of the phase being entered
  always_comb begin
    led_ew_nxt_s = LAMP_RED;
    led_ns_nxt_s = LAMP_RED;
    case (phase_nxt_s)
      PH_EW_G: led_ew_nxt_s = LAMP_GRN;
      PH_EW_Y: led_ew_nxt_s = LAMP_YEL;
      PH_NS_G: led_ns_nxt_s = LAMP_GRN;
      PH_NS_Y: led_ns_nxt_s = LAMP_YEL;
      default: begin
        led_ew_nxt_s = LAMP_RED;
        led_ns_nxt_s = LAMP_RED;
      end
    endcase
  end

  assign led_east  = led_ew_r;
  assign led_west  = led_ew_r;
  assign led_south = led_ns_r;
  assign led_north = led_ns_r;
  assign phase     = phase_r;
  assign sec_left  = sec_r;
  assign tick      = tick_r;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl: directed timing scenarios plus
// randomized requests/emergencies against an elapsed-time reference model.
module tb_traffic_phase_ctrl;

  localparam int T    = 10;
  localparam int TAR  = 1;
  localparam int GMIN = 3;
  localparam int GMAX = 6;
  localparam int TY   = 2;

  logic       clk = 1'b0;
  logic       rst, req_ew, req_ns, emg;
  logic [2:0] led_east, led_south, led_west, led_north, phase;
  logic [3:0] sec_left;
  logic       tick;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: phase, cycles spent in it, and the two pending flags
  int m_phase;
  int m_cyc;
  bit m_pew, m_pns;

  traffic_phase_ctrl #(
    .TIME_1S(T), .T_ALLRED(TAR), .G_MIN(GMIN), .G_MAX(GMAX), .T_YEL(TY)
  ) dut (
    .clk(clk), .rst(rst), .req_ew(req_ew), .req_ns(req_ns), .emg(emg),
    .led_east(led_east), .led_south(led_south), .led_west(led_west),
    .led_north(led_north), .phase(phase), .sec_left(sec_left), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int lamp_of(input int ph, input int green_ph);
    if (ph == green_ph) return 5;
    else if (ph == green_ph + 1) return 3;
    else return 6;
  endfunction

  function automatic int exp_sec();
    int done_s = m_cyc / T;
    case (m_phase)
      0, 3: return TAR - done_s;
      2, 5: return TY - done_s;
      default: return (GMIN - done_s > 1) ? GMIN - done_s : 1;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_cyc   = 0;
    m_pew   = 1'b0;
    m_pns   = 1'b0;
  endtask

  task automatic model_step();
    int  secs   = (m_cyc + 1) / T;
    bit  bound  = ((m_cyc + 1) % T) == 0;
    int  nxt    = m_phase;
    bit  frozen = 1'b0;
    bit  other;
    case (m_phase)
      0, 3: begin
        if (emg) frozen = 1'b1;
        else if (bound && secs == TAR) nxt = (m_phase == 0) ? 1 : 4;
      end
      1, 4: begin
        other = (m_phase == 1) ? m_pns : m_pew;
        if (emg) nxt = m_phase + 1;
        else if (bound && secs >= GMIN && (other || secs == GMAX)) nxt = m_phase + 1;
      end
      default: begin
        if (bound && secs == TY) nxt = (m_phase == 2) ? 3 : 0;
      end
    endcase
    if (nxt == 1 && m_phase != 1) m_pew = 1'b0;
    else if (req_ew && m_phase != 1) m_pew = 1'b1;
    if (nxt == 4 && m_phase != 4) m_pns = 1'b0;
    else if (req_ns && m_phase != 4) m_pns = 1'b1;
    m_cyc   = (nxt != m_phase || frozen) ? 0 : m_cyc + 1;
    m_phase = nxt;
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge
  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    @(negedge clk);
    cyc++;
    check_eq("phase", int'(phase), m_phase);
    check_eq("sec_left", int'(sec_left), exp_sec());
    check_eq("tick", int'(tick), int'(m_cyc % T == T - 1));
    check_eq("led_east", int'(led_east), lamp_of(m_phase, 1));
    check_eq("led_west", int'(led_west), lamp_of(m_phase, 1));
    check_eq("led_south", int'(led_south), lamp_of(m_phase, 4));
    check_eq("led_north", int'(led_north), lamp_of(m_phase, 4));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    int emg_left = 0;
    rst = 1'b1; req_ew = 1'b0; req_ns = 1'b0; emg = 1'b0;

    // No requests: AR_A 0-9, EW_G 10-69, EW_Y 70-89, AR_B 90-99, NS_G 100
    do_reset();
    check_eq("rst_phase", int'(phase), 0);
    check_eq("rst_sec", int'(sec_left), TAR);
    check_eq("rst_led", int'(led_south), 6);
    while (cyc < 101) begin
      if (cyc == 9)  check_eq("s1_ar9", int'(phase), 0);
      if (cyc == 10) check_eq("s1_ewg10", int'(phase), 1);
      if (cyc == 10) check_eq("s1_east10", int'(led_east), 5);
      if (cyc == 10) check_eq("s1_south10", int'(led_south), 6);
      if (cyc == 69) check_eq("s1_ewg69", int'(phase), 1);
      if (cyc == 70) check_eq("s1_ewy70", int'(phase), 2);
      if (cyc == 70) check_eq("s1_east70", int'(led_east), 3);
      if (cyc == 90) check_eq("s1_arb90", int'(phase), 3);
      if (cyc == 100) check_eq("s1_nsg100", int'(phase), 4);
      if (cyc == 100) check_eq("s1_north100", int'(led_north), 5);
      step();
    end

    // req_ns pulse at 15 ends EW green at G_MIN; pend_ns cleared on NS_G entry
    do_reset();
    while (cyc < 221) begin
      req_ns = (cyc == 15);
      if (cyc == 39)  check_eq("s2_ewg39", int'(phase), 1);
      if (cyc == 40)  check_eq("s2_ewy40", int'(phase), 2);
      if (cyc == 40)  check_eq("s2_sec40", int'(sec_left), 2);
      if (cyc == 70)  check_eq("s2_nsg70", int'(phase), 4);
      if (cyc == 70)  check_eq("s2_south70", int'(led_south), 5);
      if (cyc == 190) check_eq("s2_ewg190", int'(phase), 1);
      if (cyc == 220) check_eq("s2_ewy220", int'(phase), 2);
      step();
    end
    req_ns = 1'b0;

    // req_ew held during EW_G ignored; pulse in NS_Y served and cleared on entry
    do_reset();
    while (cyc < 341) begin
      req_ew = (cyc >= 10 && cyc <= 69) || (cyc == 165);
      if (cyc == 69)  check_eq("s3_ewg69", int'(phase), 1);
      if (cyc == 70)  check_eq("s3_ewy70", int'(phase), 2);
      if (cyc == 159) check_eq("s3_nsg159", int'(phase), 4);
      if (cyc == 160) check_eq("s3_nsy160", int'(phase), 5);
      if (cyc == 190) check_eq("s3_ewg190", int'(phase), 1);
      if (cyc == 250) check_eq("s3_ewy250", int'(phase), 2);
      if (cyc == 310) check_eq("s3_nsg310", int'(phase), 4);
      if (cyc == 340) check_eq("s3_nsy340", int'(phase), 5);
      step();
    end
    req_ew = 1'b0;

    // Emergency 5 cycles into NS_G, held through AR_A until cycle 175
    do_reset();
    while (cyc < 187) begin
      emg = (cyc >= 105 && cyc <= 175);
      if (cyc == 106) check_eq("s4_nsy106", int'(phase), 5);
      if (cyc == 106) check_eq("s4_sec106", int'(sec_left), 2);
      if (cyc == 125) check_eq("s4_nsy125", int'(phase), 5);
      if (cyc == 126) check_eq("s4_ara126", int'(phase), 0);
      if (cyc == 150) check_eq("s4_ara150", int'(phase), 0);
      if (cyc == 150) check_eq("s4_sec150", int'(sec_left), TAR);
      if (cyc == 185) check_eq("s4_ara185", int'(phase), 0);
      if (cyc == 186) check_eq("s4_ewg186", int'(phase), 1);
      if (cyc == 186) check_eq("s4_east186", int'(led_east), 5);
      step();
    end
    emg = 1'b0;

    // emg and req_ns on the G_MIN-end tick: one transition to EW_Y
    do_reset();
    while (cyc < 71) begin
      emg    = (cyc == 39);
      req_ns = (cyc == 39);
      if (cyc == 40) check_eq("s5_ewy40", int'(phase), 2);
      if (cyc == 40) check_eq("s5_sec40", int'(sec_left), 2);
      if (cyc == 59) check_eq("s5_ewy59", int'(phase), 2);
      if (cyc == 60) check_eq("s5_arb60", int'(phase), 3);
      if (cyc == 70) check_eq("s5_nsg70", int'(phase), 4);
      step();
    end
    emg = 1'b0; req_ns = 1'b0;

    // Reset in the last second of EW_Y after a pending NS request
    do_reset();
    while (cyc < 86) begin
      req_ns = (cyc == 75);
      if (cyc == 80) check_eq("s6_sec80", int'(sec_left), 1);
      if (cyc == 85) rst = 1'b1;
      step();
    end
    req_ns = 1'b0;
    check_eq("s6_phase", int'(phase), 0);
    check_eq("s6_east", int'(led_east), 6);
    check_eq("s6_sec", int'(sec_left), TAR);
    check_eq("s6_tick", int'(tick), 0);
    rst = 1'b0;
    cyc = 0;
    while (cyc < 71) begin
      if (cyc == 40) check_eq("s6_ewg40", int'(phase), 1);
      if (cyc == 70) check_eq("s6_ewy70", int'(phase), 2);
      step();
    end

    // Randomized requests, emergencies and occasional resets
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      req_ew = ($urandom_range(0, 99) < 3);
      req_ns = ($urandom_range(0, 99) < 3);
      if (emg_left > 0) begin
        emg_left--;
      end else if ($urandom_range(0, 299) == 0) begin
        emg_left = $urandom_range(1, 40);
      end
      emg = (emg_left > 0);
      rst = ($urandom_range(0, 1499) == 0);
      step();
    end
    rst = 1'b0; req_ew = 1'b0; req_ns = 1'b0; emg = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
